// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, holds each address MEM_WAIT cycles before sampling the
// combinational memory, and hands words to decode over valid/ready. Bad fetches latch a fault.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_WAIT  = 1,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        fault
);

    localparam logic [3:0]  WAIT_LAST = 4'(MEM_WAIT - 1);
    localparam logic [63:0] PC_LAST   = 64'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_OUT   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_r;
    logic [63:0] pc_r;
    logic [3:0]  wait_cnt_r;
    logic [31:0] instr_r;
    logic [63:0] instr_pc_r;
    logic        instr_valid_r;
    logic        fault_r;
    logic        fetch_bad_s;

    // Alignment and range check of the PC about to be captured
    always_comb begin
        fetch_bad_s = 1'b0;
        if ((pc_r[1:0] != 2'b00) || (pc_r > PC_LAST)) begin
            fetch_bad_s = 1'b1;
        end else begin
            fetch_bad_s = 1'b0;
        end
    end

    // Fetch state machine: wait/capture, hold-until-handshake, sticky fault, redirect flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_WAIT;
            pc_r          <= RESET_PC;
            wait_cnt_r    <= 4'd0;
            instr_r       <= 32'd0;
            instr_pc_r    <= 64'd0;
            instr_valid_r <= 1'b0;
            fault_r       <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over any capture or handshake in this cycle
            state_r       <= ST_WAIT;
            pc_r          <= redirect_pc;
            wait_cnt_r    <= 4'd0;
            instr_valid_r <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (enable) begin
                        if (wait_cnt_r != WAIT_LAST) begin
                            wait_cnt_r <= wait_cnt_r + 4'd1;
                        end else if (fetch_bad_s) begin
                            fault_r <= 1'b1;
                            state_r <= ST_FAULT;
                        end else begin
                            instr_r       <= imem_rdata;
                            instr_pc_r    <= pc_r;
                            instr_valid_r <= 1'b1;
                            pc_r          <= pc_r + 64'd4;
                            wait_cnt_r    <= 4'd0;
                            state_r       <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (instr_ready) begin
                        instr_valid_r <= 1'b0;
                        state_r       <= ST_WAIT;
                    end
                end
                ST_FAULT: begin
                    fault_r       <= 1'b1;
                    instr_valid_r <= 1'b0;
                end
                default: begin
                    state_r       <= ST_FAULT;
                    fault_r       <= 1'b1;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a MEM_WAIT=1 and a MEM_WAIT=3 instance share
// clock and reset; accepted instructions are checked against per-instance expectation queues.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [31:0] w;
        logic [63:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, rdy_a, redir_a;
    logic [63:0] rpc_a, addr_a, ipc_a;
    logic [31:0] rdata_a, instr_a;
    logic        valid_a, fault_a;
    logic        en_b, rdy_b, redir_b;
    logic [63:0] rpc_b, addr_b, ipc_b;
    logic [31:0] rdata_b, instr_b;
    logic        valid_b, fault_b;

    logic [7:0]  mem [0:1023];
    exp_t        qa[$];
    exp_t        qb[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        int i;
        if (a > 64'd1020) return 32'hDEAD_BEEF;
        i = int'(a);
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    assign rdata_a = word_at(addr_a);
    assign rdata_b = word_at(addr_b);

    instruction_fetch_unit #(.RESET_PC(64'h0), .MEM_WAIT(1), .MEM_BYTES(1024)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .redirect_valid(redir_a), .redirect_pc(rpc_a), .instr_valid(valid_a),
        .instr_ready(rdy_a), .instr(instr_a), .instr_pc(ipc_a), .fault(fault_a));

    instruction_fetch_unit #(.RESET_PC(64'h0), .MEM_WAIT(3), .MEM_BYTES(1024)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .redirect_valid(redir_b), .redirect_pc(rpc_b), .instr_valid(valid_b),
        .instr_ready(rdy_b), .instr(instr_b), .instr_pc(ipc_b), .fault(fault_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    // Scoreboard for instance A: every accepted instruction must be the next expected one
    always @(negedge clk) begin
        if (rst_n && valid_a && rdy_a) begin
            chk("a_expected_pending", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                exp_t e;
                e = qa.pop_front();
                chk("a_instr", 64'(instr_a), 64'(e.w));
                chk("a_instr_pc", ipc_a, e.pc);
            end
        end
    end

    // Scoreboard for instance B
    always @(negedge clk) begin
        if (rst_n && valid_b && rdy_b) begin
            chk("b_expected_pending", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                exp_t e;
                e = qb.pop_front();
                chk("b_instr", 64'(instr_b), 64'(e.w));
                chk("b_instr_pc", ipc_b, e.pc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        put_word(0, 32'h8b1f03e5);
        put_word(4, 32'hf84000a4);
        put_word(8, 32'h8b040086);
        put_word(12, 32'hf80010a6);

        rst_n = 1'b0;
        en_a = 1'b0; rdy_a = 1'b0; redir_a = 1'b0; rpc_a = 64'd0;
        en_b = 1'b0; rdy_b = 1'b0; redir_b = 1'b0; rpc_b = 64'd0;
        #3;
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_fault", 64'(fault_a), 64'd0);
        chk("rst_addr", addr_a, 64'd0);
        chk("rst_instr", 64'(instr_a), 64'd0);
        chk("rst_instr_pc", ipc_a, 64'd0);

        // Sequential stream with ready held high
        qa.push_back('{32'h8b1f03e5, 64'd0});
        qa.push_back('{32'hf84000a4, 64'd4});
        qa.push_back('{32'h8b040086, 64'd8});
        qa.push_back('{32'hf80010a6, 64'd12});
        @(negedge clk);
        rst_n = 1'b1; en_a = 1'b1; rdy_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("seq_valid_hi", 64'(valid_a), 64'd1);
            chk("seq_addr", addr_a, 64'(4 * (k + 1)));
            tick(1);
            chk("seq_valid_lo", 64'(valid_a), 64'd0);
        end
        en_a = 1'b0;
        tick(1);
        chk("seq_parked_addr", addr_a, 64'd16);

        // Redirect while holding an unaccepted instruction
        rdy_a = 1'b0; redir_a = 1'b1; rpc_a = 64'd0; en_a = 1'b1;
        tick(1);
        redir_a = 1'b0;
        tick(1);
        chk("hold_valid", 64'(valid_a), 64'd1);
        chk("hold_instr", 64'(instr_a), 64'h8b1f03e5);
        tick(2);
        chk("hold_stable_instr", 64'(instr_a), 64'h8b1f03e5);
        chk("hold_stable_pc", ipc_a, 64'd0);
        chk("hold_addr", addr_a, 64'd4);
        redir_a = 1'b1; rpc_a = 64'd8;
        tick(1);
        chk("redir_flush_valid", 64'(valid_a), 64'd0);
        chk("redir_addr", addr_a, 64'd8);
        redir_a = 1'b0; rdy_a = 1'b1;
        qa.push_back('{32'h8b040086, 64'd8});
        tick(1);
        chk("redir_deliver_valid", 64'(valid_a), 64'd1);
        en_a = 1'b0;
        tick(1);
        chk("redir_consumed", 64'(valid_a), 64'd0);

        // Misaligned redirect target faults at the capture point
        redir_a = 1'b1; rpc_a = 64'd6; en_a = 1'b1;
        tick(1);
        redir_a = 1'b0;
        tick(1);
        chk("mis_fault", 64'(fault_a), 64'd1);
        chk("mis_valid", 64'(valid_a), 64'd0);
        chk("mis_addr", addr_a, 64'd6);
        tick(2);
        chk("mis_fault_sticky", 64'(fault_a), 64'd1);
        chk("mis_valid_sticky", 64'(valid_a), 64'd0);
        qa.push_back('{32'hf84000a4, 64'd4});
        redir_a = 1'b1; rpc_a = 64'd4;
        tick(1);
        chk("mis_clear", 64'(fault_a), 64'd0);
        redir_a = 1'b0;
        tick(1);
        chk("mis_recover_valid", 64'(valid_a), 64'd1);
        en_a = 1'b0;
        tick(1);

        // Fetch up to the end of memory
        qa.push_back('{word_at(64'd1012), 64'd1012});
        qa.push_back('{word_at(64'd1016), 64'd1016});
        qa.push_back('{word_at(64'd1020), 64'd1020});
        redir_a = 1'b1; rpc_a = 64'd1012; en_a = 1'b1;
        tick(1);
        redir_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("end_valid_hi", 64'(valid_a), 64'd1);
            tick(1);
            chk("end_valid_lo", 64'(valid_a), 64'd0);
        end
        tick(1);
        chk("end_fault", 64'(fault_a), 64'd1);
        chk("end_addr", addr_a, 64'd1024);
        tick(3);
        chk("end_no_valid", 64'(valid_a), 64'd0);

        // Reset while A is holding an instruction in OUT
        rdy_a = 1'b0; redir_a = 1'b1; rpc_a = 64'd0;
        tick(1);
        redir_a = 1'b0;
        tick(1);
        chk("pre_rst_valid", 64'(valid_a), 64'd1);
        en_a = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(valid_a), 64'd0);
        chk("rst_out_fault", 64'(fault_a), 64'd0);
        chk("rst_out_addr", addr_a, 64'd0);

        // MEM_WAIT=3 latency and stall
        @(negedge clk);
        rst_n = 1'b1; en_b = 1'b1; rdy_b = 1'b0;
        qb.push_back('{32'h8b1f03e5, 64'd0});
        tick(2);
        chk("b_wait_valid", 64'(valid_b), 64'd0);
        tick(1);
        chk("b_first_valid", 64'(valid_b), 64'd1);
        chk("b_first_addr", addr_b, 64'd4);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("b_stall_valid", 64'(valid_b), 64'd1);
            chk("b_stall_instr", 64'(instr_b), 64'h8b1f03e5);
            chk("b_stall_pc", ipc_b, 64'd0);
            chk("b_stall_addr", addr_b, 64'd4);
        end
        rdy_b = 1'b1;
        tick(1);
        chk("b_consumed", 64'(valid_b), 64'd0);
        tick(2);
        chk("b_midwait_valid", 64'(valid_b), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("b_rst_valid", 64'(valid_b), 64'd0);
        chk("b_rst_fault", 64'(fault_b), 64'd0);
        chk("b_rst_addr", addr_b, 64'd0);

        // Both restart from RESET_PC
        @(negedge clk);
        rst_n = 1'b1; en_a = 1'b1; rdy_a = 1'b1; en_b = 1'b1; rdy_b = 1'b1;
        qa.push_back('{32'h8b1f03e5, 64'd0});
        qb.push_back('{32'h8b1f03e5, 64'd0});
        tick(1);
        en_a = 1'b0;
        chk("a_restart_valid", 64'(valid_a), 64'd1);
        chk("a_restart_pc", ipc_a, 64'd0);
        tick(2);
        chk("b_restart_valid", 64'(valid_b), 64'd1);
        chk("b_restart_pc", ipc_b, 64'd0);
        en_b = 1'b0;
        tick(1);
        chk("b_restart_consumed", 64'(valid_b), 64'd0);

        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
